rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port (RW, PW, LE) between two writeback requesters: the MEM-stage load return (port B, older) and the EX-stage ALU result (port A, younger).
- Accepted writes enter a shared in-order queue. The head entry drives the register-file write port one entry per cycle.
- Exports a pending-write scoreboard so decode can stall on RAW hazards against queued writes.

---
 rtl/rf_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the register file's single write port between the load return
// (port B, older in program order) and the ALU result (port A, younger).
// Accepted writes go into an in-order queue whose head drives RW/PW/LE,
// and a pending-write vector lets decode stall on RAW hazards.
//
// Optional build macro RF_WB_FWD_EN: enables the fq_* lookup that returns
// the youngest queued data for a register. Without it the fq_* outputs
// are tied to zero and no lookup logic exists.
module rf_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Clr,
  input  logic                     a_valid,
  input  logic [4:0]               a_rd,
  input  logic [31:0]              a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [4:0]               b_rd,
  input  logic [31:0]              b_data,
  output logic                     b_ready,
  input  logic                     wb_hold,
  output logic [4:0]               RW,
  output logic [31:0]              PW,
  output logic                     LE,
  output logic [31:0]              pend,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  input  logic [4:0]               fq_ra,
  input  logic [4:0]               fq_rb,
  output logic                     fq_a_hit,
  output logic [31:0]              fq_a_data,
  output logic                     fq_b_hit,
  output logic [31:0]              fq_b_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW-1:0] a_slot;
  logic [CW-1:0] free;
  logic          a_acc;
  logic          b_acc;
  logic          deq;

  // Free slots use start-of-cycle occupancy; a same-cycle dequeue gives no credit.
  assign free    = CW'(DEPTH) - count;
  assign b_ready = (free != '0);
  assign a_ready = (free >= CW'(2)) || ((free == CW'(1)) && !b_valid);

  assign b_acc  = b_valid && b_ready;
  assign a_acc  = a_valid && a_ready;
  // B is older, so it takes the first free slot and A the one after it.
  assign a_slot = wptr + AW'(b_acc);

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign deq   = !empty && !wb_hold;

  // The head entry drives the write port; writes to R0 retire silently.
  assign RW = rd_q[rptr];
  assign PW = data_q[rptr];
  assign LE = deq && (rd_q[rptr] != 5'd0);

  // Queue storage, pointers and occupancy.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      vld   <= '0;
      // NOTE: the entries are cleared too so RW/PW read zero after reset,
      // not whatever stale head the queue last held.
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let the dequeue clear and the
      // enqueue set below all see start-of-cycle pointer values.
      if (deq) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + AW'(1);
      end
      if (b_acc) begin
        rd_q[wptr]   <= b_rd;
        data_q[wptr] <= b_data;
        vld[wptr]    <= 1'b1;
      end
      if (a_acc) begin
        rd_q[a_slot]   <= a_rd;
        data_q[a_slot] <= a_data;
        vld[a_slot]    <= 1'b1;
      end
      wptr  <= wptr + AW'(b_acc) + AW'(a_acc);
      count <= count + CW'(b_acc) + CW'(a_acc) - CW'(deq);
    end
  end

  // Pending-write vector: one bit per register targeted by a live entry.
  always_comb begin
    // NOTE: defaulting every output first keeps this block latch-free.
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) pend[rd_q[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

`ifdef RF_WB_FWD_EN
  // Youngest-data lookup: scan oldest to youngest so the last match wins.
  always_comb begin
    fq_a_hit  = 1'b0;
    fq_a_data = '0;
    fq_b_hit  = 1'b0;
    fq_b_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if ((fq_ra != 5'd0) && (rd_q[rptr + AW'(k)] == fq_ra)) begin
          fq_a_hit  = 1'b1;
          fq_a_data = data_q[rptr + AW'(k)];
        end
        if ((fq_rb != 5'd0) && (rd_q[rptr + AW'(k)] == fq_rb)) begin
          fq_b_hit  = 1'b1;
          fq_b_data = data_q[rptr + AW'(k)];
        end
      end
    end
  end
`else
  logic unused_fq;
  assign unused_fq = ^{fq_ra, fq_rb};
  assign fq_a_hit  = 1'b0;
  assign fq_a_data = '0;
  assign fq_b_hit  = 1'b0;
  assign fq_b_data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenario tasks plus a negedge monitor
// that scoreboards every retirement against the expected write order.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        Clr;
  logic        a_valid, b_valid, wb_hold;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [4:0]  RW;
  logic [31:0] PW;
  logic        LE;
  logic [31:0] pend;
  logic [$clog2(DEPTH):0] count;
  logic        full, empty;
  logic [4:0]  fq_ra, fq_rb;
  logic        fq_a_hit, fq_b_hit;
  logic [31:0] fq_a_data, fq_b_data;

  rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Clr(Clr),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .wb_hold(wb_hold),
    .RW(RW), .PW(PW), .LE(LE), .pend(pend),
    .count(count), .full(full), .empty(empty),
    .fq_ra(fq_ra), .fq_rb(fq_rb),
    .fq_a_hit(fq_a_hit), .fq_a_data(fq_a_data),
    .fq_b_hit(fq_b_hit), .fq_b_data(fq_b_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic        mon_en;
  logic [31:0] rf [32];

  // Register file written by the DUT's write port.
  always @(posedge Clk) if (LE) rf[RW] <= PW;

  // Scoreboard monitor: compares ready/occupancy/pend with the model and
  // the head entry with the oldest expected write, then advances the model.
  int          sz;
  logic        exp_br, exp_ar;
  logic [31:0] exp_pend;
  wr_t         hd;
  always @(negedge Clk) begin
    if (mon_en) begin
      sz = sb.size();
      exp_br = (DEPTH - sz) >= 1;
      exp_ar = ((DEPTH - sz) >= 2) || (((DEPTH - sz) == 1) && !b_valid);
      exp_pend = '0;
      for (int i = 0; i < sz; i++) if (sb[i].rd != 5'd0) exp_pend[sb[i].rd] = 1'b1;
      n_checks++;
      if ({b_ready, a_ready} !== {exp_br, exp_ar}) begin
        n_fail++; $display("FAIL mon_ready: got b=%b a=%b expected b=%b a=%b", b_ready, a_ready, exp_br, exp_ar);
      end
      n_checks++;
      if ({count, empty, full} !== {3'(sz), sz == 0, sz == DEPTH}) begin
        n_fail++; $display("FAIL mon_count: got count=%0d empty=%b full=%b expected count=%0d", count, empty, full, sz);
      end
      n_checks++;
      if (pend !== exp_pend) begin
        n_fail++; $display("FAIL mon_pend: got %h expected %h", pend, exp_pend);
      end
      if (Clr) begin
        sb.delete();
      end else begin
        if (sz > 0) begin
          hd = sb[0];
          n_checks++;
          if ({LE, RW, PW} !== {!wb_hold && (hd.rd != 5'd0), hd.rd, hd.data}) begin
            n_fail++; $display("FAIL mon_head: got LE=%b RW=%0d PW=%h expected LE=%b RW=%0d PW=%h",
                               LE, RW, PW, !wb_hold && (hd.rd != 5'd0), hd.rd, hd.data);
          end
          if (!wb_hold) void'(sb.pop_front());
        end else begin
          n_checks++;
          if (LE !== 1'b0) begin
            n_fail++; $display("FAIL mon_idle_le: got %b expected 0", LE);
          end
        end
        if (b_valid && exp_br) sb.push_back({b_rd, b_data});
        if (a_valid && exp_ar) sb.push_back({a_rd, a_data});
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    tick(); tick();
    Clr = 1'b0;
    n_checks++;
    if ({count, LE, RW, PW, pend, empty, full} !== {3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL reset: got count=%0d LE=%b RW=%0d PW=%h pend=%h empty=%b full=%b expected zeros empty=1",
                         count, LE, RW, PW, pend, empty, full);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    n_checks++;
    if ({LE, RW, PW, pend[5]} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
      n_fail++; $display("FAIL single_head: got LE=%b RW=%0d PW=%h pend5=%b expected 1 5 deadbeef 1", LE, RW, PW, pend[5]);
    end
    tick();
    n_checks++;
    if ({pend[5], rf[5]} !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL single_retire: got pend5=%b rf5=%h expected 0 deadbeef", pend[5], rf[5]);
    end
  endtask

  task automatic test_dual();
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h11;
    a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h22;
    tick();
    idle_inputs();
    n_checks++;
    if ({count, RW} !== {3'd2, 5'd3}) begin
      n_fail++; $display("FAIL dual_first: got count=%0d RW=%0d expected 2 3", count, RW);
    end
    tick();
    n_checks++;
    if ({count, RW} !== {3'd1, 5'd4}) begin
      n_fail++; $display("FAIL dual_second: got count=%0d RW=%0d expected 1 4", count, RW);
    end
    tick();
    n_checks++;
    if (count !== 3'd0) begin
      n_fail++; $display("FAIL dual_drained: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_full();
    wb_hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_valid = 1'b1; a_rd = 5'(i); a_data = 32'(100 + i);
      tick();
    end
    b_valid = 1'b1; b_rd = 5'd8; b_data = 32'h88;
    a_rd = 5'd9; a_data = 32'h99;
    #1;
    n_checks++;
    if ({b_ready, a_ready} !== 2'b10) begin
      n_fail++; $display("FAIL full_ready: got b=%b a=%b expected b=1 a=0", b_ready, a_ready);
    end
    tick();
    idle_inputs();
    n_checks++;
    if ({full, count} !== {1'b1, 3'd4}) begin
      n_fail++; $display("FAIL full_flag: got full=%b count=%0d expected 1 4", full, count);
    end
    wb_hold = 1'b0;
    repeat (4) tick();
    n_checks++;
    if ({empty, rf[8]} !== {1'b1, 32'h88}) begin
      n_fail++; $display("FAIL full_drain: got empty=%b rf8=%h expected 1 88", empty, rf[8]);
    end
  endtask

  task automatic test_r0();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF;
    tick();
    idle_inputs();
    n_checks++;
    if ({LE, pend, count} !== {1'b0, 32'd0, 3'd1}) begin
      n_fail++; $display("FAIL r0_queued: got LE=%b pend=%h count=%0d expected 0 0 1", LE, pend, count);
    end
    tick();
    n_checks++;
    if (count !== 3'd0) begin
      n_fail++; $display("FAIL r0_retired: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_same_reg();
    wb_hold = 1'b1;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h1;
    tick();
    a_data = 32'h2;
    tick();
    idle_inputs();
    fq_ra = 5'd7;
    #1;
    n_checks++;
    if (pend[7] !== 1'b1) begin
      n_fail++; $display("FAIL same_pend_both: got %b expected 1", pend[7]);
    end
    n_checks++;
`ifdef RF_WB_FWD_EN
    if ({fq_a_hit, fq_a_data} !== {1'b1, 32'h2}) begin
      n_fail++; $display("FAIL fwd_lookup: got hit=%b data=%h expected 1 2", fq_a_hit, fq_a_data);
    end
`else
    if ({fq_a_hit, fq_a_data} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL fwd_tied: got hit=%b data=%h expected 0 0", fq_a_hit, fq_a_data);
    end
`endif
    fq_ra = 5'd0;
    wb_hold = 1'b0;
    tick();
    n_checks++;
    if (pend[7] !== 1'b1) begin
      n_fail++; $display("FAIL same_pend_one: got %b expected 1", pend[7]);
    end
    tick();
    n_checks++;
    if ({pend[7], rf[7]} !== {1'b0, 32'h2}) begin
      n_fail++; $display("FAIL same_final: got pend7=%b rf7=%h expected 0 2", pend[7], rf[7]);
    end
  endtask

  task automatic test_clr();
    wb_hold = 1'b1;
    for (int i = 9; i <= 11; i++) begin
      a_valid = 1'b1; a_rd = 5'(i); a_data = 32'(i);
      tick();
    end
    idle_inputs();
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++; $display("FAIL clr_fill: got count=%0d expected 3", count);
    end
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    n_checks++;
    if ({count, LE, pend} !== {3'd0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL clr_state: got count=%0d LE=%b pend=%h expected 0 0 0", count, LE, pend);
    end
    wb_hold = 1'b0;
    tick(); tick();
    n_checks++;
    if ({rf[9], rf[10], rf[11]} !== 96'd0) begin
      n_fail++; $display("FAIL clr_discard: got rf9=%h rf10=%h rf11=%h expected 0", rf[9], rf[10], rf[11]);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_rd    = 5'($urandom_range(0, 31));
      b_rd    = 5'($urandom_range(0, 31));
      a_data  = $urandom;
      b_data  = $urandom;
      wb_hold = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle_inputs();
    wb_hold = 1'b0;
    repeat (DEPTH + 1) tick();
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++; $display("FAIL b2b_drain: got empty=%b expected 1", empty);
    end
  endtask

  initial begin
    mon_en = 1'b0;
    Clr = 1'b1; wb_hold = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
    fq_ra = '0; fq_rb = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_single();
    test_dual();
    test_full();
    test_r0();
    test_same_reg();
    test_clr();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
